eva_mem_initiator: RTL and testbench
====================================

EVA_MEM_INITIATOR -- requirements
Module: eva_mem_initiator

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, multiple of 8, max 128.
REQ-002 SHALL have parameter AW, default 32: word address width.
REQ-003 SHALL have parameter MASKBITS, default 1: write-mask lanes, dividing WIDTH.
REQ-004 SHALL have port CLK  in  1: the single clock; all logic on posedge CLK.
REQ-005 SHALL have port RST  in  1: reset, synchronous and active-high.
REQ-006 SHALL have ports cmd_vld in 1 and cmd_rdy out 1: command handshake.
REQ-007 SHALL have ports cmd_we in 1, cmd_addr in AW, cmd_len in 4 and cmd_wmsk in MASKBITS: write flag, start address, beats-1 and active-high lane mask.
REQ-008 SHALL have ports wd_vld in 1, wd_rdy out 1 and wd_data in WIDTH: write-data beats.
REQ-009 SHALL have ports rsp_vld out 1, rsp_rdy in 1, rsp_data out WIDTH and rsp_last out 1: read-data beats.
REQ-010 SHALL have ports CS out 1, REN out 1, WEN out MASKBITS, A out AW, D out WIDTH and Q in WIDTH: SRAM-side strobes (CS, REN and WEN active-low).
REQ-011 SHALL have port busy out 1: high whenever state is not IDLE or the response buffer is not empty.

Function
REQ-012 SHALL accept a command on cmd_vld&&cmd_rdy; cmd_rdy is high only in IDLE.
REQ-013 SHALL implement FSM states IDLE, WRITE, READ and DRAIN.
REQ-014 SHALL go IDLE->WRITE on an accepted cmd_we=1 and IDLE->READ on an accepted cmd_we=0, latching addr, len and wmsk.
REQ-015 SHALL, in WRITE, drive wd_rdy=1 and on each wd_vld&&wd_rdy drive CS=0, REN=1, WEN=~wmsk, A=beat address and D=wd_data for that cycle only.
REQ-016 SHALL, in READ, issue one beat (CS=0, REN=0, WEN all 1) per cycle while the credit check of REQ-019 passes.
REQ-017 SHALL hold CS=1, REN=1, WEN all 1 and A/D at their last value in every cycle without an issued beat.
REQ-018 SHALL capture Q exactly one cycle after a read beat issues and push it into a 2-entry response FIFO.
REQ-019 SHALL issue a read beat only if FIFO occupancy plus in-flight reads is less than 2; the FIFO never overflows.
REQ-020 SHALL drive rsp_vld when the FIFO is non-empty and pop on rsp_vld&&rsp_rdy; rsp_data/rsp_last are stable while rsp_vld&&!rsp_rdy.
REQ-021 SHALL assert rsp_last on the final beat of each read command.
REQ-022 SHALL, after the last beat is issued, go WRITE->IDLE immediately and READ->DRAIN; DRAIN->IDLE once the FIFO is empty and nothing is in flight.
REQ-023 SHALL increment the beat address by 1 per beat, wrapping modulo 2^AW without an error.
REQ-024 SHALL, with cmd_wmsk all zero, still perform the beats with WEN all 1 (no-op writes).

Reset
REQ-025 SHALL, while RST=1 on a clock edge, set state IDLE, empty the FIFO, clear the in-flight and beat counters, and drive CS=1, REN=1, WEN all 1, A=0, D=0, rsp_vld=0, rsp_last=0, rsp_data=0, cmd_rdy=0, wd_rdy=0 and busy=0.
REQ-026 SHALL, on reset during a burst, abandon the burst and discard in-flight Q; cmd_rdy rises on the first clock edge after RST falls.

Configuration
REQ-027 SHALL, with EVA_MEM_INITIATOR_BURST_EN defined, honour cmd_len (1-16 beats).
REQ-028 SHALL, with EVA_MEM_INITIATOR_BURST_EN undefined, ignore cmd_len and treat every command as 1 beat with rsp_last always 1.

Structure
REQ-029 SHALL take state enum state_e and FIFO depth constant RSP_DEPTH=2 from package eva_mem_pkg.
REQ-030 SHALL place the response FIFO in sub-module eva_rsp_fifo.

Verification
REQ-031 SHALL verify: write addr=0x10, len=0, wmsk=1, data 0xA5A5A5A5 -> one cycle with CS=0, WEN=0, A=0x10, D=0xA5A5A5A5.
REQ-032 SHALL verify: read-back of addr 0x10 -> rsp_data=0xA5A5A5A5 with rsp_last=1, no earlier than 2 cycles after acceptance.
REQ-033 SHALL verify, with the macro defined: 4-beat read from 0x20 with rsp_rdy=0 -> exactly 2 beats issued, stall; releasing rsp_rdy returns 0x20..0x23 data in order, last beat flagged.
REQ-034 SHALL verify: write at addr 0xFFFFFFFF with len=1 -> beats at 0xFFFFFFFF then 0x0.
REQ-035 SHALL verify: RST=1 mid-way through a 4-beat read -> all outputs at reset values the next cycle, no rsp_vld afterwards.
REQ-036 SHALL verify, with the macro undefined: cmd_len=7 -> a single beat with rsp_last=1.

Source files
------------

// File: rtl/eva_mem_pkg.sv
// Shared types and constants for the EVA memory initiator: FSM state encoding
// and response FIFO depth.
package eva_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int RSP_DEPTH = 2;
    localparam int RSP_CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int RSP_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

endpackage

// File: rtl/eva_rsp_fifo.sv
// Small response FIFO holding {last, data} read beats; the caller guarantees
// push only when not full and pop only when not empty.
module eva_rsp_fifo
    import eva_mem_pkg::*;
#(
    parameter int W = 33
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [W-1:0]         push_data_i,
    input  logic                 pop_i,
    output logic [W-1:0]         rd_data_o,
    output logic [RSP_CNT_W-1:0] count_o,
    output logic                 empty_o
);

    logic [W-1:0]         mem_q [RSP_DEPTH];
    logic [RSP_PTR_W-1:0] wptr_q;
    logic [RSP_PTR_W-1:0] rptr_q;
    logic [RSP_CNT_W-1:0] count_q;

    function automatic logic [RSP_PTR_W-1:0] ptr_next(input logic [RSP_PTR_W-1:0] p);
        return (p == RSP_PTR_W'(RSP_DEPTH - 1)) ? '0 : p + RSP_PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= push_data_i;
                wptr_q        <= ptr_next(wptr_q);
            end
            if (pop_i) rptr_q <= ptr_next(rptr_q);
            count_q <= count_q + RSP_CNT_W'(push_i) - RSP_CNT_W'(pop_i);
        end
    end

    // Head entry is read directly so data stays stable until popped.
    assign rd_data_o = mem_q[rptr_q];
    assign count_o   = count_q;
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/eva_mem_initiator.sv
// Command-driven SRAM initiator: write bursts from wd_*, credit-limited read
// bursts into a response FIFO. Burst length honoured only with EVA_MEM_INITIATOR_BURST_EN.
module eva_mem_initiator
    import eva_mem_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int AW       = 32,
    parameter int MASKBITS = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    input  logic                cmd_we,
    input  logic [AW-1:0]       cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [MASKBITS-1:0] cmd_wmsk,
    input  logic                wd_vld,
    output logic                wd_rdy,
    input  logic [WIDTH-1:0]    wd_data,
    output logic                rsp_vld,
    input  logic                rsp_rdy,
    output logic [WIDTH-1:0]    rsp_data,
    output logic                rsp_last,
    output logic                CS,
    output logic                REN,
    output logic [MASKBITS-1:0] WEN,
    output logic [AW-1:0]       A,
    output logic [WIDTH-1:0]    D,
    input  logic [WIDTH-1:0]    Q,
    output logic                busy,
    output state_e              dbg_state
);

    // Handshakes: a transfer happens on a rising CLK edge where valid && ready;
    // valid holds its payload until accepted, ready may change at any time.

    state_e                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [MASKBITS-1:0]   wmsk_q, wmsk_d;
    logic                  pend_q, pend_d;
    logic                  pend_last_q, pend_last_d;
    logic [AW-1:0]         a_q, a_d;
    logic [WIDTH-1:0]      d_q, d_d;
    logic                  ready_q;

    logic                  fifo_empty;
    logic [RSP_CNT_W-1:0]  fifo_count;
    logic                  fifo_pop;
    logic                  credit_ok;
    logic                  beat_last;

`ifdef EVA_MEM_INITIATOR_BURST_EN
    logic [3:0] cmd_len_eff;
    assign cmd_len_eff = cmd_len;
`else
    logic [3:0] cmd_len_eff;
    logic       unused_cmd_len;
    assign cmd_len_eff    = 4'd0;
    assign unused_cmd_len = ^cmd_len;
`endif

    // Queued entries plus the read whose Q arrives next cycle must fit the FIFO.
    assign credit_ok = (fifo_count + RSP_CNT_W'(pend_q)) < RSP_CNT_W'(RSP_DEPTH);
    assign beat_last = (cnt_q == len_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        wmsk_d      = wmsk_q;
        pend_d      = 1'b0;
        pend_last_d = 1'b0;
        a_d         = a_q;
        d_d         = d_q;
        cmd_rdy     = (state_q == IDLE) && ready_q;
        wd_rdy      = 1'b0;
        CS          = 1'b1;
        REN         = 1'b1;
        WEN         = '1;
        A           = a_q;
        D           = d_q;
        case (state_q)
            IDLE: begin
                if (cmd_vld && cmd_rdy) begin
                    state_d = cmd_we ? WRITE : READ;
                    addr_d  = cmd_addr;
                    len_d   = cmd_len_eff;
                    wmsk_d  = cmd_wmsk;
                    cnt_d   = 4'd0;
                end
            end
            WRITE: begin
                wd_rdy = 1'b1;
                if (wd_vld) begin
                    CS     = 1'b0;
                    WEN    = ~wmsk_q;
                    A      = addr_q;
                    D      = wd_data;
                    a_d    = addr_q;
                    d_d    = wd_data;
                    addr_d = addr_q + AW'(1);
                    cnt_d  = cnt_q + 4'd1;
                    if (beat_last) state_d = IDLE;
                end
            end
            READ: begin
                if (credit_ok) begin
                    CS          = 1'b0;
                    REN         = 1'b0;
                    A           = addr_q;
                    a_d         = addr_q;
                    addr_d      = addr_q + AW'(1);
                    cnt_d       = cnt_q + 4'd1;
                    pend_d      = 1'b1;
                    pend_last_d = beat_last;
                    if (beat_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !pend_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            wmsk_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            a_q         <= '0;
            d_q         <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            wmsk_q      <= wmsk_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            a_q         <= a_d;
            d_q         <= d_d;
            ready_q     <= 1'b1;
        end
    end

    assign fifo_pop = rsp_vld && rsp_rdy;

    eva_rsp_fifo #(.W(WIDTH + 1)) u_rsp_fifo (
        .clk_i       (CLK),
        .rst_i       (RST),
        .push_i      (pend_q),
        .push_data_i ({pend_last_q, Q}),
        .pop_i       (fifo_pop),
        .rd_data_o   ({rsp_last, rsp_data}),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign rsp_vld   = !fifo_empty;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_eva_mem_initiator.sv
// Directed bench for eva_mem_initiator with a registered-read SRAM model;
// covers both EVA_MEM_INITIATOR_BURST_EN builds.
module tb_eva_mem_initiator;
  import eva_mem_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_vld = 1'b0, cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [0:0]  cmd_wmsk = '0;
  logic        wd_vld = 1'b0;
  logic [31:0] wd_data = '0;
  logic        rsp_rdy = 1'b0;
  logic        cmd_rdy, wd_rdy, rsp_vld, rsp_last, CS, REN, busy;
  logic [31:0] rsp_data, A, D, Q;
  logic [0:0]  WEN;
  state_e      dbg_state;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0, got_cyc = 0;

  logic [31:0] mem [0:255];
  logic [31:0] q_r = '0;
  logic [32:0] exp_q[$];
  logic [31:0] bt_a[$];
  logic [31:0] bt_d[$];
  logic        bt_ren[$];
  logic [0:0]  bt_wen[$];

  eva_mem_initiator dut (
    .CLK(CLK), .RST(RST), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wmsk(cmd_wmsk), .wd_vld(wd_vld),
    .wd_rdy(wd_rdy), .wd_data(wd_data), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .CS(CS), .REN(REN), .WEN(WEN),
    .A(A), .D(D), .Q(Q), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // SRAM model: registered read, masked write
  initial for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
  always @(posedge CLK) begin
    if (!CS && !REN) q_r <= mem[A[7:0]];
    if (!CS && REN && !WEN[0]) mem[A[7:0]] <= D;
  end
  assign Q = q_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // monitor + scoreboard
  always @(negedge CLK) begin
    if (!RST && !CS) begin
      bt_a.push_back(A);
      bt_d.push_back(D);
      bt_ren.push_back(REN);
      bt_wen.push_back(WEN);
    end
    if (!RST && rsp_vld && rsp_rdy) begin
      got_cyc = cyc;
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'(exp_q.size()), 64'd1);
      else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e[31:0]);
        chk("rsp_last", rsp_last, e[32]);
      end
    end
  end

  function automatic logic [31:0] beat_a(input int i);
    return (i < bt_a.size()) ? bt_a[i] : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] beat_d(input int i);
    return (i < bt_d.size()) ? bt_d[i] : 32'hxxxxxxxx;
  endfunction
  function automatic int read_beats();
    int n = 0;
    foreach (bt_ren[i]) if (bt_ren[i] == 1'b0) n++;
    return n;
  endfunction
  function automatic void clear_log();
    bt_a.delete(); bt_d.delete(); bt_ren.delete(); bt_wen.delete();
  endfunction

  // drivers
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [3:0] len,
                          input logic [0:0] msk);
    logic acc = 1'b0;
    cmd_vld = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_wmsk = msk;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (cmd_rdy) acc = 1'b1;
      tick();
    end
    acc_cyc = cyc;
    cmd_vld = 1'b0;
    chk("cmd_accept", acc, 1'b1);
  endtask

  task automatic send_wd(input logic [31:0] data);
    logic acc = 1'b0;
    wd_vld = 1'b1; wd_data = data;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (wd_rdy) acc = 1'b1;
      tick();
    end
    wd_vld = 1'b0;
    chk("wd_accept", acc, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) tick();
    chk(tag, busy, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs"}, CS, 1'b1);
    chk({tag, "_ren"}, REN, 1'b1);
    chk({tag, "_wen"}, WEN, 1'b1);
    chk({tag, "_a"}, A, 32'h0);
    chk({tag, "_d"}, D, 32'h0);
    chk({tag, "_rsp_vld"}, rsp_vld, 1'b0);
    chk({tag, "_rsp_last"}, rsp_last, 1'b0);
    chk({tag, "_rsp_data"}, rsp_data, 32'h0);
    chk({tag, "_cmd_rdy"}, cmd_rdy, 1'b0);
    chk({tag, "_wd_rdy"}, wd_rdy, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    int vld_seen;
    // reset state
    RST = 1'b1;
    tick(); tick();
    chk_reset_outputs("rst");
    RST = 1'b0;
    #1;
    chk("cmd_rdy_before_edge", cmd_rdy, 1'b0);
    tick();
    chk("cmd_rdy_after_rst", cmd_rdy, 1'b1);

    // single write to 0x10
    clear_log();
    send_cmd(1'b1, 32'h10, 4'd0, 1'b1);
    send_wd(32'hA5A5A5A5);
    wait_idle("idle_wr10");
    chk("wr10_beats", 64'(bt_a.size()), 64'd1);
    chk("wr10_a", beat_a(0), 32'h10);
    chk("wr10_d", beat_d(0), 32'hA5A5A5A5);
    chk("wr10_ren", (bt_ren.size() > 0) ? bt_ren[0] : 1'bx, 1'b1);
    chk("wr10_wen", (bt_wen.size() > 0) ? bt_wen[0] : 1'bx, 1'b0);
    chk("hold_a", A, 32'h10);
    chk("hold_d", D, 32'hA5A5A5A5);

    // read back 0x10
    rsp_rdy = 1'b1;
    exp_q.push_back({1'b1, 32'hA5A5A5A5});
    send_cmd(1'b0, 32'h10, 4'd0, 1'b1);
    wait_idle("idle_rd10");
    chk("rd10_latency_ge2", 64'((got_cyc - acc_cyc) >= 2), 64'd1);

`ifdef EVA_MEM_INITIATOR_BURST_EN
    // 4-beat read with back-pressure: credit limits issue to 2 beats
    clear_log();
    rsp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 32'hC0DE0020 + 32'(i)});
    send_cmd(1'b0, 32'h20, 4'd3, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    chk("stall_reads", 64'(read_beats()), 64'd2);
    chk("stall_rsp_vld", rsp_vld, 1'b1);
    chk("stall_data", rsp_data, 32'hC0DE0020);
    chk("stall_last", rsp_last, 1'b0);
    tick(); tick();
    chk("stall_data_stable", rsp_data, 32'hC0DE0020);
    chk("stall_busy", busy, 1'b1);
    rsp_rdy = 1'b1;
    wait_idle("idle_burst_rd");
    chk("burst_reads", 64'(read_beats()), 64'd4);
    for (int i = 0; i < 4; i++) chk("burst_addr", beat_a(i), 32'h20 + 32'(i));
`else
    // length ignored: one beat, last flagged
    clear_log();
    rsp_rdy = 1'b1;
    exp_q.push_back({1'b1, 32'hC0DE0030});
    send_cmd(1'b0, 32'h30, 4'd7, 1'b1);
    wait_idle("idle_len7");
    chk("len7_reads", 64'(read_beats()), 64'd1);
    chk("len7_addr", beat_a(0), 32'h30);
`endif

    // address wrap
    clear_log();
    send_cmd(1'b1, 32'hFFFFFFFF, 4'd1, 1'b1);
    send_wd(32'h11111111);
`ifdef EVA_MEM_INITIATOR_BURST_EN
    send_wd(32'h22222222);
    wait_idle("idle_wrap");
    chk("wrap_beats", 64'(bt_a.size()), 64'd2);
    chk("wrap_a0", beat_a(0), 32'hFFFFFFFF);
    chk("wrap_a1", beat_a(1), 32'h0);
    chk("wrap_d1", beat_d(1), 32'h22222222);
`else
    wait_idle("idle_wrap");
    chk("wrap_beats", 64'(bt_a.size()), 64'd1);
    chk("wrap_a0", beat_a(0), 32'hFFFFFFFF);
`endif

    // zero mask: beat still issued, no lane enabled
    clear_log();
    send_cmd(1'b1, 32'h40, 4'd0, 1'b0);
    send_wd(32'hDEADBEEF);
    wait_idle("idle_nomask");
    chk("nomask_beats", 64'(bt_a.size()), 64'd1);
    chk("nomask_wen", (bt_wen.size() > 0) ? bt_wen[0] : 1'bx, 1'b1);
    chk("nomask_a", beat_a(0), 32'h40);

    // reset mid-way through a read burst
    rsp_rdy = 1'b0;
    send_cmd(1'b0, 32'h50, 4'd3, 1'b1);
    tick(); tick();
    chk("midrd_busy", busy, 1'b1);
    RST = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    RST = 1'b0;
    rsp_rdy = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_vld) vld_seen++;
    end
    chk("midrst_no_rsp", 64'(vld_seen), 64'd0);
    chk("midrst_cmd_rdy", cmd_rdy, 1'b1);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
